// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles every signal exchanged between the system RAM port arbiter,
// its four requesters (video, CPU, FDD reader, ioctl writer) and the sram
// controller.
//
// Signal summary:
//   vid/cpu/fdd/misc_req   level requests, held until the matching ack
//   vid/cpu/fdd/misc_addr  request addresses (AW bits)
//   cpu_we, misc_we        write qualifiers (video and FDD are read-only)
//   cpu_din, misc_din      write data
//   ack[3:0]               one-cycle completion pulses (0=vid 1=cpu 2=fdd 3=misc)
//   rd_data                data of the last completed read
//   grant_id               requester owning the current/last transaction
//   busy, err              FSM not idle / transaction aborted (pulsed with ack)
//   mem_req/we/addr/din    transaction start and latched request to the sram
//   mem_ready, mem_dout    completion and read data from the sram
//
// Modports:
//   master - requesters and sram controller side (drives requests, ready)
//   slave  - arbiter side
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int AW = 25
);
   logic          vid_req;
   logic          cpu_req;
   logic          fdd_req;
   logic          misc_req;
   logic [AW-1:0] vid_addr;
   logic [AW-1:0] cpu_addr;
   logic [AW-1:0] fdd_addr;
   logic [AW-1:0] misc_addr;
   logic          cpu_we;
   logic          misc_we;
   logic [7:0]    cpu_din;
   logic [7:0]    misc_din;
   logic [3:0]    ack;
   logic [7:0]    rd_data;
   logic [1:0]    grant_id;
   logic          busy;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          mem_ready;
   logic [7:0]    mem_dout;

   modport master (
      output vid_req, cpu_req, fdd_req, misc_req,
      output vid_addr, cpu_addr, fdd_addr, misc_addr,
      output cpu_we, misc_we, cpu_din, misc_din,
      input  ack, rd_data, grant_id, busy, err,
      input  mem_req, mem_we, mem_addr, mem_din,
      output mem_ready, mem_dout
   );

   modport slave (
      input  vid_req, cpu_req, fdd_req, misc_req,
      input  vid_addr, cpu_addr, fdd_addr, misc_addr,
      input  cpu_we, misc_we, cpu_din, misc_din,
      output ack, rd_data, grant_id, busy, err,
      output mem_req, mem_we, mem_addr, mem_din,
      input  mem_ready, mem_dout
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares the single 8-bit system RAM port between video fetch, CPU,
// FDD image-buffer reader and ARM ioctl download writer. One transaction is
// in flight at a time (IDLE -> ISSUE -> WAIT -> DONE). Video has strict
// priority; CPU, FDD and ioctl ("misc") rotate round-robin so a long disk
// load cannot starve the CPU.
//
// Ports:
//   clk_sys  system clock, all logic on posedge
//   reset    asynchronous, active-high
//   bus      mem_port_arbiter_if.slave (requests, acks, sram port)
//
// Parameters:
//   AW       address width of every requester and of the memory port
//   TIMEOUT  WAIT cycles before a stalled transaction is aborted
//            (only with MEMARB_TIMEOUT_EN; must fit the 4-bit counter)
//
// Build option:
//   MEMARB_TIMEOUT_EN  when defined, a transaction that sees no mem_ready for
//                      TIMEOUT WAIT cycles completes with rd_data=8'hFF and
//                      err=1. When undefined, WAIT waits forever and err is 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW      = 25,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_sys,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ID_VID  = 2'd0;
   localparam logic [1:0] ID_CPU  = 2'd1;
   localparam logic [1:0] ID_FDD  = 2'd2;
   localparam logic [1:0] ID_MISC = 2'd3;

   // The wait counter is 4 bits wide; anything outside 1..15 cannot be honoured.
   if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_timeout_range
      $error("mem_port_arbiter: TIMEOUT must be in 1..15");
   end

   state_t        state_q,    state_d;
   logic [1:0]    grant_q,    grant_d;
   logic [1:0]    rr_ptr_q,   rr_ptr_d;
   logic [3:0]    excl_q,     excl_d;
   logic          mem_we_q,   mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_din_q,  mem_din_d;
   logic [7:0]    rd_data_q,  rd_data_d;
   logic          err_q,      err_d;

   logic [3:0]    req_vec;
   logic [1:0]    cand0, cand1, cand2;
   logic [1:0]    win;
   logic          timeout_hit;

`ifdef MEMARB_TIMEOUT_EN
   localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

   logic [3:0]    to_cnt_q, to_cnt_d;

   // to_cnt counts completed WAIT cycles; the TIMEOUT-th one without
   // mem_ready aborts.
   assign timeout_hit = (to_cnt_q == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Round-robin successor among the shared sources: cpu -> fdd -> misc -> cpu.
   function automatic logic [1:0] rr_next(input logic [1:0] id);
      return (id == ID_MISC) ? ID_CPU : id + 2'd1;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] id);
      return 4'b0001 << id;
   endfunction

   // Next-state and datapath latch decisions
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      excl_d     = 4'b0000;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      rd_data_d  = rd_data_q;
      err_d      = err_q;
`ifdef MEMARB_TIMEOUT_EN
      to_cnt_d   = to_cnt_q;
`endif

      // The source acked in the previous cycle is masked for one IDLE cycle,
      // giving it time to drop its level request before being re-granted.
      req_vec = {bus.misc_req, bus.fdd_req, bus.cpu_req, bus.vid_req} & ~excl_q;

      cand0 = rr_ptr_q;
      cand1 = rr_next(cand0);
      cand2 = rr_next(cand1);

      if (req_vec[ID_VID]) begin
         win = ID_VID;
      end else if (req_vec[cand0]) begin
         win = cand0;
      end else if (req_vec[cand1]) begin
         win = cand1;
      end else begin
         win = cand2;
      end

      case (state_q)
         S_IDLE: begin
            if (|req_vec) begin
               grant_d = win;
               err_d   = 1'b0;
               state_d = S_ISSUE;
               case (win)
                  ID_VID: begin
                     mem_addr_d = bus.vid_addr;
                     mem_we_d   = 1'b0;
                     mem_din_d  = 8'h00;
                  end
                  ID_CPU: begin
                     mem_addr_d = bus.cpu_addr;
                     mem_we_d   = bus.cpu_we;
                     mem_din_d  = bus.cpu_din;
                  end
                  ID_FDD: begin
                     mem_addr_d = bus.fdd_addr;
                     mem_we_d   = 1'b0;
                     mem_din_d  = 8'h00;
                  end
                  default: begin
                     mem_addr_d = bus.misc_addr;
                     mem_we_d   = bus.misc_we;
                     mem_din_d  = bus.misc_din;
                  end
               endcase
            end
         end

         // mem_ready is deliberately not looked at here: the controller only
         // sees mem_req during this cycle, so a ready now is stale.
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef MEMARB_TIMEOUT_EN
            to_cnt_d = 4'd0;
`endif
         end

         S_WAIT: begin
            if (bus.mem_ready) begin
               if (!mem_we_q) begin
                  rd_data_d = bus.mem_dout;
               end
               state_d = S_DONE;
            end else if (timeout_hit) begin
               rd_data_d = 8'hFF;
               err_d     = 1'b1;
               state_d   = S_DONE;
            end else begin
`ifdef MEMARB_TIMEOUT_EN
               to_cnt_d = to_cnt_q + 4'd1;
`endif
            end
         end

         S_DONE: begin
            // Video grants do not consume a round-robin slot.
            if (grant_q != ID_VID) begin
               rr_ptr_d = rr_next(grant_q);
            end
            excl_d  = onehot(grant_q);
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched transaction registers
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         grant_q    <= ID_VID;
         rr_ptr_q   <= ID_CPU;
         excl_q     <= 4'b0000;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= 8'h00;
         rd_data_q  <= 8'hFF;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         excl_q     <= excl_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
      end
   end

`ifdef MEMARB_TIMEOUT_EN
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         to_cnt_q <= 4'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`endif

   // Outputs are decoded from registered state only, so they are glitch-free
   // and never depend combinationally on requester inputs.
   assign bus.ack      = (state_q == S_DONE) ? onehot(grant_q) : 4'b0000;
   assign bus.err      = (state_q == S_DONE) & err_q;
   assign bus.mem_req  = (state_q == S_ISSUE);
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.grant_id = grant_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by randomized transactions. A transaction-level
// reference model (round-robin pointer, one-cycle exclusion of the last
// grantee, last read data) predicts the winner, latched request and read data
// for each transaction; the bench plays the sram controller.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int AW = 25;

   logic clk_sys = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_port_arbiter_if #(.AW(AW)) bus ();

   mem_port_arbiter #(.AW(AW), .TIMEOUT(15)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   // Source stimulus values (index 0=vid 1=cpu 2=fdd 3=misc)
   logic [AW-1:0] s_addr [4];
   logic          s_we   [4];
   logic [7:0]    s_din  [4];

   // Reference model state
   int         m_ptr;    // next shared source in rotation (1..3)
   int         m_excl;   // source masked for the coming IDLE evaluation, -1 none
   logic [7:0] m_rd;     // last read data

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic model_reset();
      m_ptr  = 1;
      m_excl = -1;
      m_rd   = 8'hFF;
   endtask

   task automatic apply(input logic [3:0] req);
      bus.vid_req   = req[0];
      bus.cpu_req   = req[1];
      bus.fdd_req   = req[2];
      bus.misc_req  = req[3];
      bus.vid_addr  = s_addr[0];
      bus.cpu_addr  = s_addr[1];
      bus.fdd_addr  = s_addr[2];
      bus.misc_addr = s_addr[3];
      bus.cpu_we    = s_we[1];
      bus.misc_we   = s_we[3];
      bus.cpu_din   = s_din[1];
      bus.misc_din  = s_din[3];
   endtask

   // Winner: video if requesting, else first of ptr, ptr+1, ptr+2 (mod 3 over 1..3).
   function automatic int predict(input logic [3:0] req, input int excl);
      logic [3:0] eff;
      eff = req;
      if (excl >= 0) eff[excl] = 1'b0;
      if (eff[0]) return 0;
      for (int k = 0; k < 3; k++) begin
         int id;
         id = 1 + ((m_ptr - 1 + k) % 3);
         if (eff[id]) return id;
      end
      return -1;
   endfunction

   // Called with the DUT in IDLE. Runs one full transaction and returns the
   // winner; leaves the DUT in the IDLE cycle following the ack.
   task automatic run_txn(input logic [3:0] req, input int extra_wait,
                          input logic spurious, input logic [7:0] rdat,
                          output int w);
      logic [AW-1:0] e_addr;
      logic          e_we;
      logic [7:0]    e_din;
      apply(req);
      w = predict(req, m_excl);
      if (w < 0) begin
         // only the just-acked source asks: one idle cycle, then it wins
         m_excl = -1;
         step();
         chk("idle_hold_busy_req", {30'd0, bus.busy, bus.mem_req}, 32'd0);
         w = predict(req, -1);
      end
      m_excl = -1;
      if (w < 0) begin
         chk("no_request_given", 32'd0, 32'd1);
         return;
      end
      e_addr = s_addr[w];
      e_we   = (w == 1 || w == 3) ? s_we[w] : 1'b0;
      e_din  = s_din[w];

      step();  // ISSUE
      chk("issue_mem_req",  {31'd0, bus.mem_req}, 32'd1);
      chk("issue_grant_id", {30'd0, bus.grant_id}, w);
      chk("issue_mem_addr", {7'd0, bus.mem_addr}, {7'd0, e_addr});
      chk("issue_mem_we",   {31'd0, bus.mem_we}, {31'd0, e_we});
      chk("issue_ack",      {28'd0, bus.ack}, 32'd0);
      if (e_we) chk("issue_mem_din", {24'd0, bus.mem_din}, {24'd0, e_din});
      if (spurious) begin
         bus.mem_ready = 1'b1;
         bus.mem_dout  = ~rdat;
      end

      step();  // first WAIT cycle
      bus.mem_ready = 1'b0;
      chk("wait_mem_req", {30'd0, bus.busy, bus.mem_req}, 32'd2);
      for (int i = 0; i < extra_wait; i++) begin
         step();
         chk("wait_ack", {28'd0, bus.ack}, 32'd0);
         chk("wait_addr_stable", {7'd0, bus.mem_addr}, {7'd0, e_addr});
      end

      bus.mem_ready = 1'b1;
      bus.mem_dout  = rdat;
      step();  // DONE
      bus.mem_ready = 1'b0;
      bus.mem_dout  = 8'($urandom);
      if (!e_we) m_rd = rdat;
      chk("done_ack",      {28'd0, bus.ack}, 32'd1 << w);
      chk("done_rd_data",  {24'd0, bus.rd_data}, {24'd0, m_rd});
      chk("done_err",      {31'd0, bus.err}, 32'd0);
      chk("done_mem_addr", {7'd0, bus.mem_addr}, {7'd0, e_addr});
      if (e_we) chk("done_mem_din", {24'd0, bus.mem_din}, {24'd0, e_din});
      if (w != 0) m_ptr = (w % 3) + 1;
      m_excl = w;

      step();  // back in IDLE
      chk("ack_single_pulse", {28'd0, bus.ack}, 32'd0);
      chk("idle_busy",        {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_mem_req"},  {31'd0, bus.mem_req}, 32'd0);
      chk({tag, "_mem_we"},   {31'd0, bus.mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, {7'd0, bus.mem_addr}, 32'd0);
      chk({tag, "_mem_din"},  {24'd0, bus.mem_din}, 32'd0);
      chk({tag, "_ack"},      {28'd0, bus.ack}, 32'd0);
      chk({tag, "_err"},      {31'd0, bus.err}, 32'd0);
      chk({tag, "_busy"},     {31'd0, bus.busy}, 32'd0);
      chk({tag, "_grant_id"}, {30'd0, bus.grant_id}, 32'd0);
      chk({tag, "_rd_data"},  {24'd0, bus.rd_data}, 32'hFF);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      step();
      reset = 1'b0;
      model_reset();
   endtask

   int w;
   int exp_rr   [6] = '{1, 2, 3, 1, 2, 3};
   int exp_vm   [4] = '{0, 3, 0, 3};
   int exp_all  [6] = '{0, 1, 0, 2, 0, 3};

   initial begin
      for (int i = 0; i < 4; i++) begin
         s_addr[i] = AW'(32'h100 * (i + 1));
         s_we[i]   = 1'b0;
         s_din[i]  = 8'h00;
      end
      reset         = 1'b1;
      bus.mem_ready = 1'b0;
      bus.mem_dout  = 8'h00;
      apply(4'hF);
      model_reset();

      // Reset held with all requests high and stray mem_ready: nothing starts
      for (int i = 0; i < 3; i++) begin
         bus.mem_ready = (i == 1);
         step();
         check_reset_values("rst");
      end
      bus.mem_ready = 1'b0;
      reset = 1'b0;
      run_txn(4'hF, 0, 1'b0, 8'h11, w);
      chk("rst_release_vid_first", w, 32'd0);

      // CPU alone, read of 0x0004000 returning A5 after 2 WAIT cycles
      do_reset();
      s_addr[1] = 25'h0004000;
      s_we[1]   = 1'b0;
      run_txn(4'b0010, 2, 1'b1, 8'hA5, w);
      chk("cpu_alone_grant", w, 32'd1);
      chk("cpu_alone_rd", {24'd0, bus.rd_data}, 32'hA5);

      // CPU, FDD, misc held: strict rotation
      do_reset();
      s_we[3] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         run_txn(4'b1110, i % 3, 1'b0, 8'(8'h20 + i), w);
         chk("rr_sequence", w, exp_rr[i]);
      end

      // Video + misc write of 3C to 0x1000000
      do_reset();
      s_addr[3] = 25'h1000000;
      s_we[3]   = 1'b1;
      s_din[3]  = 8'h3C;
      for (int i = 0; i < 4; i++) begin
         run_txn(4'b1001, 1, 1'b0, 8'(8'h40 + i), w);
         chk("vid_misc_sequence", w, exp_vm[i]);
      end
      // misc writes must not disturb the last video read data
      chk("write_keeps_rd", {24'd0, bus.rd_data}, 32'h42);

      // All four requesting: video interleaves with the rotation
      do_reset();
      s_we[1] = 1'b0;
      s_we[3] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         run_txn(4'hF, 0, 1'b0, 8'(8'h60 + i), w);
         chk("all_four_sequence", w, exp_all[i]);
      end

      // Reset asserted during WAIT, then a late mem_ready
      do_reset();
      apply(4'b0010);
      step();  // ISSUE
      step();  // WAIT
      chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      #1;
      check_reset_values("rst_wait");
      apply(4'b0000);
      step();
      reset = 1'b0;
      model_reset();
      bus.mem_ready = 1'b1;
      bus.mem_dout  = 8'h5A;
      step();
      bus.mem_ready = 1'b0;
      chk("late_ready_ack",  {28'd0, bus.ack}, 32'd0);
      chk("late_ready_busy", {31'd0, bus.busy}, 32'd0);
      chk("late_ready_rd",   {24'd0, bus.rd_data}, 32'hFF);
      step();
      chk("late_ready_ack2", {28'd0, bus.ack}, 32'd0);

      // No mem_ready for a long time
`ifdef MEMARB_TIMEOUT_EN
      apply(4'b0010);
      step();  // ISSUE
      for (int i = 0; i < 15; i++) begin
         step();
         chk("timeout_wait_ack", {28'd0, bus.ack}, 32'd0);
      end
      step();
      chk("timeout_ack", {28'd0, bus.ack}, 32'd2);
      chk("timeout_err", {31'd0, bus.err}, 32'd1);
      chk("timeout_rd",  {24'd0, bus.rd_data}, 32'hFF);
      m_rd   = 8'hFF;
      m_ptr  = 2;
      m_excl = 1;
      step();
      chk("timeout_err_pulse", {31'd0, bus.err}, 32'd0);
`else
      run_txn(4'b0010, 100, 1'b0, 8'h77, w);
      chk("long_wait_grant", w, 32'd1);
`endif

      // Randomized traffic, requests changing between transactions
      for (int t = 0; t < 40; t++) begin
         logic [3:0] rq;
         for (int i = 0; i < 4; i++) begin
            s_addr[i] = AW'($urandom);
            s_we[i]   = 1'($urandom);
            s_din[i]  = 8'($urandom);
         end
         rq = 4'($urandom_range(1, 15));
         run_txn(rq, $urandom_range(0, 3), 1'($urandom), 8'($urandom), w);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 8-bit system RAM port between four requesters: video fetch, CPU, FDD image-buffer reader and ARM ioctl download writer.
- Sits between these requesters and the sram controller. Sequences one transaction at a time with a request/ready handshake.
- Video has strict priority. CPU, FDD and ioctl share the remaining slots round-robin, so a long disk load cannot starve the CPU.

Parameters:
- AW, 25, address width of every requester and of the memory port.
- TIMEOUT, 15, maximum WAIT cycles before abort. Used only with MEMARB_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- vid_req, cpu_req, fdd_req, misc_req  in  1 each  level requests; held until the matching ack.
- vid_addr, cpu_addr, fdd_addr, misc_addr  in  AW each  request addresses.
- cpu_we, misc_we  in  1 each  write qualifiers. Video and FDD are read-only; their we is forced to 0.
- cpu_din, misc_din  in  8 each  write data.
- ack  out  4  one-cycle completion pulses. Bit0=vid, bit1=cpu, bit2=fdd, bit3=misc.
- rd_data  out  8  data of the last completed read; valid from the ack cycle until the next ack.
- grant_id  out  2  requester owning the current or last transaction.
- busy  out  1  high when the FSM is in any state other than IDLE.
- err  out  1  abort flag, pulsed together with ack.
- mem_req  out  1  one-cycle start pulse to the sram controller.
- mem_we  out  1  write strobe, latched per transaction.
- mem_addr  out  AW  latched address.
- mem_din  out  8  latched write data.
- mem_ready  in  1  one-cycle completion from the sram controller.
- mem_dout  in  8  read data, valid when mem_ready=1.

Behaviour:
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_din=0, ack=0, err=0, busy=0, grant_id=0, rd_data=8'hFF. Round-robin pointer = cpu. FSM = IDLE.
- Reset mid-transaction: returns to IDLE immediately. No ack is issued for the aborted transaction. A late mem_ready arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request pending: stay in IDLE.
- IDLE, any request pending:
  - If vid_req=1, video wins.
  - Otherwise the first requesting source searching pointer, pointer+1, pointer+2 (cpu->fdd->misc->cpu) wins.
  - Latch winner's addr, we and din into mem_*. Set grant_id. Go to ISSUE.
- ISSUE: mem_req=1 for exactly this cycle. Go to WAIT.
- WAIT:
  - On mem_ready: rd_data <= mem_dout (reads only; writes leave rd_data unchanged). Go to DONE.
  - mem_ready in the same cycle as ISSUE is not sampled; only WAIT samples it.
- DONE:
  - ack[grant_id]=1 for one cycle.
  - If the grantee was cpu, fdd or misc, pointer <= grantee+1 with wrap misc->cpu. A video grant leaves the pointer unchanged.
  - Go to IDLE. The just-acked requester is excluded from IDLE arbitration in the next cycle, allowing one cycle to drop req.
- Latency:
  - Request sampled in IDLE at cycle N -> mem_req at N+1.
  - mem_ready at cycle M -> ack at M+1.
  - Minimum turnaround is 4 cycles when mem_ready arrives on the first WAIT cycle.
- Simultaneous requests: all four asserted -> order vid, cpu, vid, fdd, vid, misc while vid stays asserted. With vid idle -> cpu, fdd, misc, cpu ...
- Request dropped before grant: ignored, no ack. A request dropped after ISSUE still completes and acks.
- mem_addr, mem_we and mem_din stay stable from ISSUE through DONE.

Optional Feature:
- MEMARB_TIMEOUT_EN defined:
  - A 4-bit counter runs in WAIT.
  - If TIMEOUT cycles elapse without mem_ready, go to DONE with rd_data=8'hFF and err=1 alongside ack.
  - The pointer advances normally.
- Undefined: WAIT lasts indefinitely until mem_ready arrives, and err is constant 0.

Test Plan:
- Reset: assert reset with all req high -> all outputs at reset values, mem_req never pulses. Release -> vid granted first, mem_req at the cycle after release sampling.
- cpu_req alone, cpu_addr=25'h0004000, cpu_we=0; mem_ready after 2 WAIT cycles with mem_dout=8'hA5 -> mem_addr=25'h0004000, ack[1] one cycle after mem_ready, rd_data=8'hA5.
- cpu, fdd, misc held high, vid low, 6 transactions -> grant_id sequence 1,2,3,1,2,3. Each ack is a single-cycle pulse.
- vid and misc held high -> grant sequence 0,3,0,3. misc writes 8'h3C to 25'h1000000 and mem_din=8'h3C for the whole transaction.
- Reset asserted in WAIT, then mem_ready pulsed -> no ack, FSM IDLE, rd_data=8'hFF.
- With MEMARB_TIMEOUT_EN, no mem_ready -> ack and err after 15 WAIT cycles, rd_data=8'hFF. Without the macro -> no ack after 100 cycles.
